// File: rtl/dc_pkg.sv
// Shared encodings for the dc_datapath PID engine: mux selects, EEPROM map,
// sequencer state encoding and multiply length.
package dc_pkg;

  localparam int DC_MULT_STEPS = 14;

  localparam logic [1:0] DC_EEP_XSET = 2'b00;
  localparam logic [1:0] DC_EEP_P    = 2'b01;
  localparam logic [1:0] DC_EEP_I    = 2'b10;
  localparam logic [1:0] DC_EEP_D    = 2'b11;

  localparam logic [2:0] A_CFGDATA  = 3'd0;
  localparam logic [2:0] A_XMEAS    = 3'd1;
  localparam logic [2:0] A_ERR      = 3'd2;
  localparam logic [2:0] A_PROD2815 = 3'd3;
  localparam logic [2:0] A_DUTY     = 3'd4;
  localparam logic [2:0] A_SUMERRA  = 3'd5;
  localparam logic [2:0] A_DIFERR   = 3'd6;
  localparam logic [2:0] A_ZEROA    = 3'd7;

  localparam logic [2:0] B_XSET      = 3'd0;
  localparam logic [2:0] B_SUMERRB   = 3'd1;
  localparam logic [2:0] B_PREVERR   = 3'd2;
  localparam logic [2:0] B_ZEROB     = 3'd3;
  localparam logic [2:0] B_PID       = 3'd4;
  localparam logic [2:0] B_POSACKA5A = 3'd5;
  localparam logic [2:0] B_PROD2512  = 3'd6;
  localparam logic [2:0] B_EEPDATA   = 3'd7;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_RD_XSET   = 4'd1,
    S_LD_XSET   = 4'd2,
    S_ERR       = 4'd3,
    S_SUMERR    = 4'd4,
    S_DIFERR    = 4'd5,
    S_PREVERR   = 4'd6,
    S_RD_COEF   = 4'd7,
    S_LD_COEF   = 4'd8,
    S_MULT_INIT = 4'd9,
    S_MULT      = 4'd10,
    S_ACCUM     = 4'd11,
    S_DONE      = 4'd12
  } state_t;

endpackage

// File: rtl/dc_pid_seq.sv
// PID update sequencer: error front end, then three coefficient/Booth-multiply/
// accumulate passes (P, I, D) driving the dc_datapath selects and strobes.
module dc_pid_seq
  import dc_pkg::*;
#(
  parameter int         MULT_STEPS = DC_MULT_STEPS,
  parameter logic [1:0] EEP_XSET   = DC_EEP_XSET,
  parameter logic [1:0] EEP_P      = DC_EEP_P,
  parameter logic [1:0] EEP_I      = DC_EEP_I,
  parameter logic [1:0] EEP_D      = DC_EEP_D
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [1:0] c_prod,
  output logic [1:0] eep_addr,
  output logic [2:0] c_asel,
  output logic [2:0] c_bsel,
  output logic       c_err,
  output logic       c_duty,
  output logic       c_sumerr,
  output logic       c_diferr,
  output logic       c_xset,
  output logic       c_preverr,
  output logic       c_pid,
  output logic       c_init_prod,
  output logic       c_subtract,
  output logic       c_multsat,
  output logic       c_clr_duty,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] LAST_STEP = 4'(MULT_STEPS - 1);

  state_t     r_state, w_next;
  logic [1:0] r_term;
  logic [3:0] r_step;
  logic [1:0] w_coef_addr;
  logic [2:0] w_mult_asel;
  logic       w_last_step;
  logic       w_term_bad;

  assign w_last_step = (r_step == LAST_STEP);
  assign w_term_bad  = (r_term == 2'd3);

  always_comb begin
    w_coef_addr = EEP_P;
    w_mult_asel = A_ERR;
    case (r_term)
      2'd1:    begin w_coef_addr = EEP_I; w_mult_asel = A_SUMERRA; end
      2'd2:    begin w_coef_addr = EEP_D; w_mult_asel = A_DIFERR;  end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_term  <= 2'd0;
      r_step  <= 4'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_PREVERR)
        r_term <= 2'd0;
      else if (r_state == S_ACCUM && r_term != 2'd2)
        r_term <= r_term + 2'd1;
      if (r_state == S_MULT_INIT || (r_state == S_MULT && w_last_step))
        r_step <= 4'd0;
      else if (r_state == S_MULT)
        r_step <= r_step + 4'd1;
    end
  end

  always_comb begin
    w_next      = r_state;
    eep_addr    = EEP_XSET;
    c_asel      = A_ZEROA;
    c_bsel      = B_ZEROB;
    c_err       = 1'b0;
    c_duty      = 1'b0;
    c_sumerr    = 1'b0;
    c_diferr    = 1'b0;
    c_xset      = 1'b0;
    c_preverr   = 1'b0;
    c_pid       = 1'b0;
    c_init_prod = 1'b0;
    c_subtract  = 1'b0;
    c_multsat   = 1'b0;
    c_clr_duty  = 1'b0;
    busy        = (r_state != S_IDLE);
    done        = 1'b0;
    case (r_state)
      S_IDLE:    if (go) w_next = S_RD_XSET;
      S_RD_XSET: w_next = S_LD_XSET;
      S_LD_XSET: begin
        c_xset = 1'b1;
        c_bsel = B_EEPDATA;
        w_next = S_ERR;
      end
      S_ERR: begin
        c_err      = 1'b1;
        c_subtract = 1'b1;
        c_asel     = A_XMEAS;
        c_bsel     = B_XSET;
        w_next     = S_SUMERR;
      end
      S_SUMERR: begin
        c_sumerr = 1'b1;
        c_asel   = A_ERR;
        c_bsel   = B_SUMERRB;
        w_next   = S_DIFERR;
      end
      S_DIFERR: begin
        c_diferr   = 1'b1;
        c_subtract = 1'b1;
        c_asel     = A_ERR;
        c_bsel     = B_PREVERR;
        w_next     = S_PREVERR;
      end
      S_PREVERR: begin
        // duty is cleared here so an aborted run never leaks into the next
        c_preverr  = 1'b1;
        c_clr_duty = 1'b1;
        c_asel     = A_ERR;
        w_next     = S_RD_COEF;
      end
      S_RD_COEF: begin
        eep_addr = w_coef_addr;
        w_next   = w_term_bad ? S_IDLE : S_LD_COEF;
      end
      S_LD_COEF: begin
        eep_addr = w_coef_addr;
        c_pid    = 1'b1;
        c_bsel   = B_EEPDATA;
        w_next   = w_term_bad ? S_IDLE : S_MULT_INIT;
      end
      S_MULT_INIT: begin
        c_init_prod = 1'b1;
        c_asel      = w_mult_asel;
        w_next      = w_term_bad ? S_IDLE : S_MULT;
      end
      S_MULT: begin
        // Booth pair decode is combinational on the live product LSBs
        c_asel = A_PROD2815;
        case (c_prod)
          2'b01:   c_bsel = B_PID;
          2'b10:   begin c_bsel = B_PID; c_subtract = 1'b1; end
          default: c_bsel = B_ZEROB;
        endcase
        if (w_term_bad)       w_next = S_IDLE;
        else if (w_last_step) w_next = S_ACCUM;
      end
      S_ACCUM: begin
        c_duty    = 1'b1;
        c_multsat = 1'b1;
        c_asel    = A_DUTY;
        c_bsel    = B_PROD2512;
        if (w_term_bad)           w_next = S_IDLE;
        else if (r_term == 2'd2)  w_next = S_DONE;
        else                      w_next = S_RD_COEF;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dc_pid_seq.sv
// Directed bench for dc_pid_seq: a per-cycle expected output vector built from
// the cycle timeline is queued on drive and compared at the falling edge.
module tb_dc_pid_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       go = 1'b0;
  logic [1:0] c_prod = 2'b00;
  logic [1:0] eep_addr;
  logic [2:0] c_asel, c_bsel;
  logic c_err, c_duty, c_sumerr, c_diferr, c_xset, c_preverr, c_pid;
  logic c_init_prod, c_subtract, c_multsat, c_clr_duty, busy, done;

  int n_vec = 0;
  int n_mis = 0;
  int cnt_pid, cnt_sat, cnt_clr, cnt_done, done_at;
  logic [20:0] sb[$];

  always #5 clk = ~clk;

  dc_pid_seq dut (
    .clk(clk), .rst(rst), .go(go), .c_prod(c_prod), .eep_addr(eep_addr),
    .c_asel(c_asel), .c_bsel(c_bsel), .c_err(c_err), .c_duty(c_duty),
    .c_sumerr(c_sumerr), .c_diferr(c_diferr), .c_xset(c_xset),
    .c_preverr(c_preverr), .c_pid(c_pid), .c_init_prod(c_init_prod),
    .c_subtract(c_subtract), .c_multsat(c_multsat), .c_clr_duty(c_clr_duty),
    .busy(busy), .done(done)
  );

  // {eep_addr, asel, bsel, err, duty, sumerr, diferr, xset, preverr, pid,
  //  init_prod, subtract, multsat, clr_duty, busy, done}
  function automatic logic [20:0] obs_vec();
    return {eep_addr, c_asel, c_bsel, c_err, c_duty, c_sumerr, c_diferr, c_xset,
            c_preverr, c_pid, c_init_prod, c_subtract, c_multsat, c_clr_duty,
            busy, done};
  endfunction

  // c = cycle within a run (go sampled at the end of cycle 0); anything
  // outside 1..61 is idle.
  function automatic logic [20:0] exp_vec(int c, logic [1:0] p);
    logic [1:0] ea = 2'd0;
    logic [2:0] a = 3'd7, b = 3'd3;
    logic err = 0, duty = 0, sumerr = 0, diferr = 0, xset = 0, preverr = 0;
    logic pid = 0, init = 0, sub = 0, sat = 0, clr = 0;
    int t, k;
    case (c)
      2: begin xset = 1; b = 3'd7; end
      3: begin err = 1; sub = 1; a = 3'd1; b = 3'd0; end
      4: begin sumerr = 1; a = 3'd2; b = 3'd1; end
      5: begin diferr = 1; sub = 1; a = 3'd2; b = 3'd2; end
      6: begin preverr = 1; clr = 1; a = 3'd2; end
      default: ;
    endcase
    if (c >= 7 && c <= 60) begin
      t = (c - 7) / 18;
      k = (c - 7) % 18;
      if (k == 0) ea = 2'(t + 1);
      else if (k == 1) begin ea = 2'(t + 1); pid = 1; b = 3'd7; end
      else if (k == 2) begin init = 1; a = (t == 0) ? 3'd2 : (t == 1) ? 3'd5 : 3'd6; end
      else if (k <= 16) begin
        a = 3'd3;
        if (p == 2'b01) b = 3'd4;
        else if (p == 2'b10) begin b = 3'd4; sub = 1; end
      end else begin duty = 1; sat = 1; a = 3'd4; b = 3'd6; end
    end
    return {ea, a, b, err, duty, sumerr, diferr, xset, preverr, pid, init, sub,
            sat, clr, (c >= 1 && c <= 61), (c == 61)};
  endfunction

  task automatic chk(input string tag, input int obs, input int expv);
    n_vec++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Entered just after a rising edge; drives inputs for this cycle, checks at
  // the falling edge, and leaves just after the next rising edge.
  task automatic cyc(input logic g, input logic [1:0] p, input int c);
    logic [20:0] o, e;
    go = g;
    c_prod = p;
    sb.push_back(exp_vec(c, p));
    @(negedge clk);
    o = obs_vec();
    e = sb.pop_front();
    n_vec++;
    assert (o === e) else begin
      n_mis++;
      $error("FAIL vec cyc=%0d observed=%h expected=%h", c, o, e);
    end
    cnt_pid += int'(c_pid);
    cnt_sat += int'(c_multsat);
    cnt_clr += int'(c_clr_duty);
    if (done === 1'b1) begin cnt_done++; done_at = c; end
    @(posedge clk);
    #1;
  endtask

  task automatic clr_counts();
    cnt_pid = 0; cnt_sat = 0; cnt_clr = 0; cnt_done = 0; done_at = -1;
  endtask

  initial begin
    logic [1:0] pr;
    clr_counts();
    // reset held: outputs at defaults
    #2;
    sb.push_back(exp_vec(-1, 2'b00));
    n_vec++;
    assert (obs_vec() === sb[0]) else begin
      n_mis++;
      $error("FAIL reset observed=%h expected=%h", obs_vec(), sb[0]);
    end
    void'(sb.pop_front());
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // idle with go low
    for (int i = 0; i < 20; i++) cyc(1'b0, 2'($urandom_range(0, 3)), -1);

    // run 1: go pulse, c_prod 00 throughout
    clr_counts();
    for (int c = 0; c <= 63; c++) cyc(c == 0, 2'b00, c);
    chk("pid_count", cnt_pid, 3);
    chk("multsat_count", cnt_sat, 3);
    chk("clr_duty_count", cnt_clr, 1);
    chk("done_cycle", done_at, 61);

    // run 2: alternating Booth pairs, go re-pulsed mid-run is ignored
    clr_counts();
    for (int c = 0; c <= 70; c++) cyc(c == 0 || c == 30, (c % 2) ? 2'b01 : 2'b10, c);
    chk("done_count_repulse", cnt_done, 1);

    // run 3: go held high across two runs
    clr_counts();
    for (int c = 0; c <= 125; c++) cyc(c <= 122, 2'($urandom_range(0, 3)), (c >= 62) ? c - 62 : c);
    chk("done_count_held", cnt_done, 2);
    chk("second_done_cycle", done_at + 62, 123);

    // run 4: reset asserted in a MULT cycle of term I
    clr_counts();
    for (int c = 0; c < 32; c++) cyc(c == 0, 2'($urandom_range(0, 3)), c);
    c_prod = 2'b10;
    #1 rst = 1'b1;
    #1;
    sb.push_back(exp_vec(-1, c_prod));
    n_vec++;
    assert (obs_vec() === sb[0]) else begin
      n_mis++;
      $error("FAIL mid_reset observed=%h expected=%h", obs_vec(), sb[0]);
    end
    void'(sb.pop_front());
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) cyc(1'b0, 2'b01, -1);

    // fresh run after the abort
    clr_counts();
    for (int c = 0; c <= 63; c++) begin
      pr = 2'($urandom_range(0, 3));
      cyc(c == 0, pr, c);
    end
    chk("post_reset_done_cycle", done_at, 61);
    chk("post_reset_clr_duty", cnt_clr, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dc_pid_seq.md
# dc_pid_seq

Control sequencer for the `dc_datapath` PID engine. On each `go` it computes one full duty update:
- loads Xset from EEPROM and forms err, sumerr, diferr and preverr;
- for each of the P, I and D terms, loads the coefficient, runs the 14-step Booth multiply and accumulates the saturated product into duty.

It drives all datapath mux selects and register strobes, and sits between the top-level control FSM and `dc_datapath`.

## Interface
Parameters:
- `MULT_STEPS`, 14: Booth iterations per multiply.
- `EEP_XSET`, 2'b00: EEPROM address of Xset.
- `EEP_P`, 2'b01: EEPROM address of the P coefficient.
- `EEP_I`, 2'b10: EEPROM address of the I coefficient.
- `EEP_D`, 2'b11: EEPROM address of the D coefficient.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `go` in 1: start a control cycle; sampled only in IDLE.
- `c_prod` in 2: Booth pair from the datapath product LSBs.
- `eep_addr` out 2: EEPROM read address; read data is valid the cycle after the address is presented.
- `c_asel` out 3: datapath A-mux select.
- `c_bsel` out 3: datapath B-mux select.
- `c_err`, `c_duty`, `c_sumerr`, `c_diferr`, `c_xset`, `c_preverr`, `c_pid`, `c_init_prod`, `c_subtract`, `c_multsat`, `c_clr_duty` out 1 each: datapath strobes.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when duty has been updated.

## Operation
**Select encodings**
- A-mux: CFGDATA=0, XMEAS=1, ERR=2, PROD2815=3, DUTY=4, SUMERRA=5, DIFERR=6, ZEROA=7.
- B-mux: XSET=0, SUMERRB=1, PREVERR=2, ZEROB=3, PID=4, POSACKA5A=5, PROD2512=6, EEPDATA=7.

**Default (every state unless listed):** all strobes 0, `c_asel`=ZEROA, `c_bsel`=ZEROB, `eep_addr`=EEP_XSET.

**States and outputs**
- IDLE: `go` → RD_XSET; otherwise stay.
- RD_XSET: `eep_addr`=EEP_XSET → LD_XSET.
- LD_XSET: `c_xset`, B=EEPDATA, A=ZEROA → ERR.
- ERR: `c_err`, `c_subtract`, A=XMEAS, B=XSET → SUMERR.
- SUMERR: `c_sumerr`, A=ERR, B=SUMERRB → DIFERR.
- DIFERR: `c_diferr`, `c_subtract`, A=ERR, B=PREVERR → PREVERR.
- PREVERR: `c_preverr`, A=ERR, B=ZEROB, `c_clr_duty`; clear term index → RD_COEF.
- RD_COEF: `eep_addr` = EEP_P, EEP_I or EEP_D by term index (0,1,2) → LD_COEF.
- LD_COEF: `c_pid`, B=EEPDATA, `eep_addr` held → MULT_INIT.
- MULT_INIT: `c_init_prod`, B=ZEROB, A = ERR / SUMERRA / DIFERR for term 0/1/2; clear step counter → MULT.
- MULT: A=PROD2815; Booth decode on `c_prod`:
  - 2'b01: B=PID.
  - 2'b10: B=PID, `c_subtract`.
  - 2'b00 or 2'b11: B=ZEROB.
  - Counter increments each cycle; after MULT_STEPS cycles → ACCUM.
- ACCUM: `c_duty`, `c_multsat`, A=DUTY, B=PROD2512. Term index 2 → DONE; otherwise increment index → RD_COEF.
- DONE: `done`=1 → IDLE.

**Registers and counters**
- Term index: 2 bits, values 0..2; value 3 is unreachable and forces IDLE.
- Step counter: 4 bits, values 0..MULT_STEPS−1.

**Boundary conditions**
- `go` while `busy`: ignored, never queued.
- `go` held high: a new cycle starts in the IDLE cycle after DONE.
- `rst` asserted mid-cycle: immediate return to IDLE, all outputs at defaults; the datapath keeps partial values, and the next cycle recomputes duty from `c_clr_duty`.

## Timing
- Outputs are combinational from state. They are Moore, except `c_bsel`/`c_subtract` in MULT, which decode `c_prod` combinationally.
- Reset values: state=IDLE, both counters=0, `busy`=0, `done`=0, all strobes 0, A=7, B=3, `eep_addr`=0.
- `go` sampled at edge 0 → RD_XSET in cycle 1.
- Front end occupies cycles 1–6.
- Each term takes 18 cycles (RD_COEF 1, LD_COEF 1, MULT_INIT 1, MULT 14, ACCUM 1), occupying cycles 7–60.
- DONE occurs in cycle 61; `busy` is high in cycles 1–61.
- Minimum go-to-go spacing is 62 cycles.

## Structure
- Shared package `dc_pkg`: A/B select localparams, EEPROM address constants, state encoding (4-bit), MULT_STEPS.
- No sub-module: the step counter and term index live inline. Output decode is one combinational block.

## Test plan
- Reset then idle with `go`=0 → `busy`=0, A=7, B=3, no strobes for 20 cycles.
- Pulse `go`, `c_prod` held 2'b00 → strobe order matches the states above; `done` in cycle 61; exactly 14 MULT cycles per term with B=ZEROB.
- `c_prod` alternating 01/10 in MULT → B=PID every MULT cycle; `c_subtract` only on the 10 cycles.
- `eep_addr` sequence across one run = 0, 1, 2, 3, each held through its LD cycle; `c_pid` fires exactly 3×; `c_multsat` 3×; `c_clr_duty` 1×.
- `go` re-pulsed at cycle 30 → ignored, single `done`; `go` held high → second `done` at cycle 123.
- `rst` asserted in MULT of term I → outputs at defaults within the same cycle; a fresh `go` produces a full 61-cycle run.
